keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner that drives one column at a time, synchronises and debounces the row returns, and encodes the pressed key into a binary code of the form row*COLS + col. A single-entry output register with a valid/ready handshake delivers the code. The block sits between the keypad pins and the display/control logic, and generalises the fixed 4x4 key encoder to arbitrary ROWS x COLS with its own scan, debounce and optional auto-repeat.

## Interface
- ROWS, 4, number of row inputs (≥2)
- COLS, 4, number of driven columns (≥2)
- SCAN_CYCLES, 16, clock cycles each column is driven (≥3)
- DEBOUNCE_CYCLES, 50000, cycles a level must be stable before it is accepted on press and on release (≥1)
- REPEAT_DELAY, 25_000_000, hold cycles before the first auto-repeat (repeat build only)
- REPEAT_PERIOD, 5_000_000, cycles between subsequent repeats (repeat build only)
- Derived: CODE_W = $clog2(ROWS*COLS)
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- row_i  in  ROWS  raw row returns, active-high, asynchronous to clk
- col_o  out  COLS  one-hot active-high column drive
- key_code_o  out  CODE_W  code of the accepted key, row*COLS + col
- key_valid_o  out  1  key_code_o holds an unconsumed code
- key_ready_i  in  1  consumer accepts the code when it is high together with key_valid_o
- key_held_o  out  1  a debounced key is currently held
- overrun_o  out  1  one-cycle pulse when a code is dropped because the output register is full

## Operation
- Reset values: col_o = 1 (column 0), key_code_o = 0, key_valid_o = 0, key_held_o = 0, overrun_o = 0, FSM = SCAN, all counters = 0.
- row_i passes through a 2-flop synchroniser. All decisions use the synchronised rows (rs).
- SCAN: drive col c for SCAN_CYCLES, then sample rs on the last dwell cycle. If rs == 0, advance c; c wraps from COLS-1 to 0. If rs != 0, latch r = lowest set row index, freeze c, and go to DEBOUNCE.
- DEBOUNCE: count while rs[r] is high. If rs[r] drops, go to SCAN and advance c. When the count reaches DEBOUNCE_CYCLES, emit code r*COLS+c, set key_held_o, and go to HELD.
- HELD: c stays frozen. When rs[r] goes low, go to RELEASE.
- RELEASE: count while rs[r] is low. If rs[r] goes high again, return to HELD without a new emit. When the count reaches DEBOUNCE_CYCLES, clear key_held_o, advance c, and go to SCAN.
- Emit rule: a code is loaded if the output register is empty or is being accepted in the same cycle (key_valid_o && key_ready_i). Otherwise the new code is dropped, the old code is kept, and overrun_o pulses.
- Handshake: while key_valid_o is high, key_code_o is stable. The transfer completes on a cycle where key_valid_o && key_ready_i. If an emit coincides with acceptance, the new code loads and key_valid_o stays high.
- Multiple rows pressed on one column: the lowest row wins. Other columns are not scanned while a key is held.
- Reset asserted mid-operation clears all state immediately. No code is emitted after release of reset until a full debounce completes.

## Timing
- Synchroniser latency: 2 cycles. SCAN_CYCLES ≥ 3 guarantees the sample reflects the driven column.
- Detection sample at cycle T. Then key_valid_o = 1 and the new key_code_o are visible at T+DEBOUNCE_CYCLES+1.
- A full scan of an idle keypad takes COLS*SCAN_CYCLES cycles.
- overrun_o is high for exactly one cycle per dropped code.

## Configuration
- KEYPAD_REPEAT_EN defined: in HELD, a counter runs. A repeat emit of the same code occurs REPEAT_DELAY cycles after the initial emit, then every REPEAT_PERIOD cycles. Repeats obey the emit/overrun rule. The counter clears on leaving HELD, and a RELEASE bounce back to HELD restarts it from 0.
- KEYPAD_REPEAT_EN undefined: exactly one emit per debounced press. The REPEAT_* parameters are ignored and no repeat logic is generated.

## Structure
- keypad_pkg: state enum (SCAN, DEBOUNCE, HELD, RELEASE) and the code function row*COLS+col.
- Sub-module keypad_row_sync: ROWS-wide 2-flop synchroniser, reset to 0 by rst_n.

## Test plan
Settings unless stated: ROWS=4, COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, key_ready_i=1.
- Reset with row_i=0 → col_o=4'b0001 and all other outputs 0. col_o rotates 0001→0010→0100→1000→0001, 4 cycles per column.
- Hold row 2 high only while col 1 is driven, stable → one emit, key_code_o=9, key_valid_o for 1 cycle, key_held_o=1. Release → key_held_o clears 8 cycles after rs low and scanning resumes at col 2.
- Row 1 on col 3 bounces low after 5 debounce cycles → no emit, scan resumes at col 0. Stable retry → key_code_o=7.
- key_ready_i=0, press keys 0 then 5 → key_code_o stays 0 and overrun_o pulses once on the second emit. Raise key_ready_i → the handshake completes with code 0.
- Press col 0 rows 1 and 3 together → key_code_o=4. Emit coincides with acceptance of a pending code → new code loads and key_valid_o stays 1.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, hold key 15 for 60 cycles after the first emit → emits at +0, +20, +30, +40, +50. Assert rst_n=0 mid-hold → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the matrix keypad scanner.
//   state_t  - scanner FSM states (SCAN, DEBOUNCE, HELD, RELEASE)
//   key_code - linear key code row*cols + col
//   max_u    - larger of two unsigned values, for counter sizing
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic int unsigned key_code(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchroniser for the asynchronous row returns.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset, clears both stages to 0
//   row_raw  - raw row inputs, asynchronous to clk
//   row_sync - synchronised rows, two cycles behind row_raw
module keypad_row_sync #(
    parameter int unsigned ROWS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_raw,
    output logic [ROWS-1:0] row_sync
);

    logic [ROWS-1:0] meta;

    // First stage may go metastable; only the second stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            row_sync <= '0;
        end else begin
            meta     <= row_raw;
            row_sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWS x COLS matrix keypad scanner with debounce and a
// single-entry valid/ready output register.
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat while a key
// is held (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   row_i       - raw active-high row returns
//   col_o       - one-hot active-high column drive
//   key_code_o  - code of the accepted key, row*COLS + col
//   key_valid_o - key_code_o holds an unconsumed code
//   key_ready_i - consumer accepts when high together with key_valid_o
//   key_held_o  - a debounced key is currently held
//   overrun_o   - one-cycle pulse when a code is dropped (register full)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ROWS-1:0]               row_i,
    output logic [COLS-1:0]               col_o,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code_o,
    output logic                          key_valid_o,
    input  logic                          key_ready_i,
    output logic                          key_held_o,
    output logic                          overrun_o
);

    localparam int unsigned CODE_W  = $clog2(ROWS * COLS);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned CNT_MAX = max_u(SCAN_CYCLES, DEBOUNCE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Reject illegal configurations at elaboration.
    if (ROWS < 2 || COLS < 2 || SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter value");
    end

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [COL_W-1:0]    col_idx, col_nxt, col_adv;
    logic [ROW_W-1:0]    row_idx, row_nxt, low_row;
    logic [COLS-1:0]     col_o_nxt;
    logic [CODE_W-1:0]   code_nxt, code_emit;
    logic                valid_nxt, held_nxt, overrun_nxt;
    logic                emit;
    logic [ROWS-1:0]     rs;
    logic                rs_sel;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt, rep_target;
    logic             rep_armed, rep_armed_nxt;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    assign rep_target = rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
`endif

    keypad_row_sync #(
        .ROWS     (ROWS)
    ) u_row_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_raw  (row_i),
        .row_sync (rs)
    );

    assign rs_sel    = rs[row_idx];
    assign col_adv   = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
    assign code_emit = CODE_W'(key_code(32'(row_idx), 32'(col_idx), COLS));

    // Lowest set row wins when several rows return on one column.
    always_comb begin
        low_row = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (rs[i]) low_row = ROW_W'(i);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            cnt         <= '0;
            col_idx     <= '0;
            row_idx     <= '0;
            col_o       <= COLS'(1);
            key_code_o  <= '0;
            key_valid_o <= 1'b0;
            key_held_o  <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_armed   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            col_idx     <= col_nxt;
            row_idx     <= row_nxt;
            col_o       <= col_o_nxt;
            key_code_o  <= code_nxt;
            key_valid_o <= valid_nxt;
            key_held_o  <= held_nxt;
            overrun_o   <= overrun_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= rep_cnt_nxt;
            rep_armed   <= rep_armed_nxt;
`endif
        end
    end

    // Next-state, emit request and output-register update.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        col_nxt     = col_idx;
        row_nxt     = row_idx;
        held_nxt    = key_held_o;
        emit        = 1'b0;
        code_nxt    = key_code_o;
        valid_nxt   = key_valid_o & ~key_ready_i;
        overrun_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nxt   = '0;
        rep_armed_nxt = 1'b0;
`endif

        case (state)
            SCAN: begin
                // Sample only on the last dwell cycle so the synchroniser
                // has caught up with the newly driven column.
                if (cnt == CNT_W'(SCAN_CYCLES - 1)) begin
                    cnt_nxt = '0;
                    if (rs == '0) begin
                        col_nxt = col_adv;
                    end else begin
                        row_nxt   = low_row;
                        state_nxt = DEBOUNCE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DEBOUNCE: begin
                if (!rs_sel) begin
                    state_nxt = SCAN;
                    col_nxt   = col_adv;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    emit      = 1'b1;
                    held_nxt  = 1'b1;
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            HELD: begin
                if (!rs_sel) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_cnt == rep_target) begin
                        emit          = 1'b1;
                        rep_cnt_nxt   = '0;
                        rep_armed_nxt = 1'b1;
                    end else begin
                        rep_cnt_nxt   = rep_cnt + REP_W'(1);
                        rep_armed_nxt = rep_armed;
                    end
`endif
                end
            end

            RELEASE: begin
                // A bounce back high returns to HELD without a new code.
                if (rs_sel) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    held_nxt  = 1'b0;
                    col_nxt   = col_adv;
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = SCAN;
                cnt_nxt   = '0;
            end
        endcase

        // Load when empty or being drained this cycle; otherwise drop.
        if (emit) begin
            if (!key_valid_o || key_ready_i) begin
                code_nxt  = code_emit;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end

        col_o_nxt = COLS'(1) << col_nxt;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scoreboard bench for keypad_scanner.
// A matrix model turns the pressed-key set and the driven column into row
// returns; expected codes are queued at press time and a negedge monitor
// pops and compares them on every valid/ready transfer.
// Build with +define+KEYPAD_REPEAT_EN to also exercise auto-repeat.
module tb_keypad_scanner;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned SCAN   = 4;
    localparam int unsigned DEB    = 8;
    localparam int unsigned RDLY   = 20;
    localparam int unsigned RPER   = 10;
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);

    logic                 clk;
    logic                 rst_n;
    logic [ROWS-1:0]      row_i;
    logic [COLS-1:0]      col_o;
    logic [CODE_W-1:0]    key_code_o;
    logic                 key_valid_o;
    logic                 key_ready;
    logic                 key_held_o;
    logic                 overrun_o;

    logic [ROWS-1:0][COLS-1:0] keys;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  ov_seen = 0;
    int  ov_exp = 0;
    int  exp_q[$];
    bit  rand_ready = 1'b0;
    bit  prev_pending = 1'b0;
    logic [CODE_W-1:0] prev_code = '0;

    keypad_scanner #(
        .ROWS            (ROWS),
        .COLS            (COLS),
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_PERIOD   (RPER)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready),
        .key_held_o  (key_held_o),
        .overrun_o   (overrun_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key connects its row to its column.
    always_comb begin
        row_i = '0;
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                if (keys[r][c] && col_o[c]) row_i[r] = 1'b1;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [COLS-1:0] onehot(input int c);
        logic [COLS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    // Monitor: compare every transfer against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_pending)
                check(key_valid_o && key_code_o == prev_code, "pending_stable",
                      int'(key_code_o), int'(prev_code));
            if (key_valid_o && key_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_emit", int'(key_code_o), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check(int'(key_code_o) == e, "key_code", int'(key_code_o), e);
                end
            end
            if (overrun_o) ov_seen++;
            prev_pending = key_valid_o && !key_ready;
            prev_code    = key_code_o;
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Press (row r plus extra rows) on column c, starting while c is idle.
    task automatic press_key(input int r, input int c, input logic [ROWS-1:0] extra,
                             input bit push, input int ready_at, output int h0);
        int t0;
        int g;
        g = 0;
        while (col_o == onehot(c) && g < 100) begin tick(1); g++; end
        keys[r][c] = 1'b1;
        for (int i = 0; i < int'(ROWS); i++) if (extra[i]) keys[i][c] = 1'b1;
        if (push) exp_q.push_back(r * int'(COLS) + c);
        g = 0;
        while (col_o != onehot(c) && g < 100) begin tick(1); g++; end
        t0 = cyc;
        g = 0;
        while (!key_held_o && g < 200) begin
            if (ready_at >= 0 && cyc - t0 == ready_at) key_ready = 1'b1;
            tick(1);
            g++;
        end
        check(key_held_o == 1'b1, "held_set", int'(key_held_o), 1);
        check(cyc - t0 == int'(SCAN + DEB), "press_latency", cyc - t0, int'(SCAN + DEB));
        h0 = cyc;
    endtask

    // Release everything; held clears after sync (2) + DEB + 1 cycles.
    task automatic release_key(input int c);
        int u0;
        int g;
        keys = '0;
        u0 = cyc;
        g = 0;
        while (key_held_o && g < 100) begin tick(1); g++; end
        check(cyc - u0 == int'(DEB) + 3, "release_latency", cyc - u0, int'(DEB) + 3);
        check(col_o == onehot((c + 1) % int'(COLS)), "resume_col",
              int'(col_o), int'(onehot((c + 1) % int'(COLS))));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin tick(1); g++; end
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int t0;
        int g;
        rst_n     = 1'b0;
        key_ready = 1'b1;
        keys      = '0;
        tick(3);
        check(col_o == COLS'(1), "reset_col", int'(col_o), 1);
        check(key_code_o == '0, "reset_code", int'(key_code_o), 0);
        check(!key_valid_o, "reset_valid", int'(key_valid_o), 0);
        check(!key_held_o, "reset_held", int'(key_held_o), 0);
        check(!overrun_o, "reset_overrun", int'(overrun_o), 0);

        // Idle rotation: column k/SCAN mod COLS.
        rst_n = 1'b1;
        for (int k = 0; k < 2 * int'(COLS * SCAN); k++) begin
            check(col_o == onehot((k / int'(SCAN)) % int'(COLS)), "scan_rotation",
                  int'(col_o), int'(onehot((k / int'(SCAN)) % int'(COLS))));
            tick(1);
        end

        // Row 2 on column 1 -> code 9, single-cycle valid with ready high.
        press_key(2, 1, '0, 1'b1, -1, h0);
        check(key_code_o == CODE_W'(9), "code_9", int'(key_code_o), 9);
        tick(1);
        check(!key_valid_o, "valid_one_cycle", int'(key_valid_o), 0);
        tick(8);
        release_key(1);

        // Row 1 on column 3 bounces low mid-debounce: no code, scan to col 0.
        g = 0;
        while (col_o == onehot(3) && g < 100) begin tick(1); g++; end
        keys[1][3] = 1'b1;
        g = 0;
        while (col_o != onehot(3) && g < 100) begin tick(1); g++; end
        t0 = cyc;
        while (cyc < t0 + int'(SCAN) + 5) tick(1);
        keys = '0;
        while (cyc < t0 + int'(SCAN + DEB)) tick(1);
        check(col_o == onehot(0), "bounce_resume_col", int'(col_o), 1);
        check(!key_held_o, "bounce_no_hold", int'(key_held_o), 0);
        press_key(1, 3, '0, 1'b1, -1, h0);
        check(key_code_o == CODE_W'(7), "code_7", int'(key_code_o), 7);
        tick(5);
        release_key(3);

        // Consumer stalled: second code is dropped and overrun pulses once.
        key_ready = 1'b0;
        press_key(0, 0, '0, 1'b1, -1, h0);
        release_key(0);
        press_key(1, 1, '0, 1'b0, -1, h0);
        ov_exp++;
        check(overrun_o == 1'b1, "overrun_pulse", int'(overrun_o), 1);
        check(key_code_o == '0, "code_kept", int'(key_code_o), 0);
        tick(1);
        check(!overrun_o, "overrun_one_cycle", int'(overrun_o), 0);
        release_key(1);
        key_ready = 1'b1;
        drain();

        // Rows 1 and 3 on column 0 -> code 4, left pending; next emit
        // coincides with its acceptance and valid stays high.
        key_ready = 1'b0;
        press_key(1, 0, ROWS'(4'b1000), 1'b1, -1, h0);
        release_key(0);
        press_key(2, 2, '0, 1'b1, int'(SCAN + DEB) - 1, h0);
        check(key_valid_o == 1'b1, "coincide_valid", int'(key_valid_o), 1);
        check(key_code_o == CODE_W'(10), "coincide_code", int'(key_code_o), 10);
        release_key(2);
        drain();

        // Randomized presses with random consumer back-pressure.
        for (int it = 0; it < 12; it++) begin
            int r;
            int c;
            logic [ROWS-1:0] extra;
            c = int'($urandom_range(0, COLS - 1));
            r = int'($urandom_range(0, ROWS - 1));
            extra = '0;
            for (int i = r + 1; i < int'(ROWS); i++) extra[i] = 1'($urandom_range(0, 1));
            rand_ready = 1'b1;
            press_key(r, c, extra, 1'b1, -1, h0);
            tick(int'($urandom_range(1, 12)));
            release_key(c);
            rand_ready = 1'b0;
            key_ready  = 1'b1;
            drain();
        end

`ifdef KEYPAD_REPEAT_EN
        begin : repeat_test
            int offs[$];
            int want;
            press_key(3, 3, '0, 1'b1, -1, h0);
            for (int k = 1; k < 5; k++) exp_q.push_back(15);
            for (int k = 0; k <= 55; k++) begin
                if (key_valid_o) offs.push_back(cyc - h0);
                tick(1);
            end
            check(offs.size() == 5, "repeat_count", offs.size(), 5);
            for (int k = 0; k < 5 && k < offs.size(); k++) begin
                want = (k == 0) ? 0 : int'(RDLY) + (k - 1) * int'(RPER);
                check(offs[k] == want, "repeat_offset", offs[k], want);
            end
            release_key(3);
        end
`endif

        // Asynchronous reset while a key is held.
        press_key(0, 2, '0, 1'b1, -1, h0);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check(col_o == COLS'(1), "async_reset_col", int'(col_o), 1);
        check(key_code_o == '0, "async_reset_code", int'(key_code_o), 0);
        check(!key_valid_o, "async_reset_valid", int'(key_valid_o), 0);
        check(!key_held_o, "async_reset_held", int'(key_held_o), 0);
        check(!overrun_o, "async_reset_overrun", int'(overrun_o), 0);
        keys = '0;
        tick(2);
        rst_n = 1'b1;
        check(col_o == COLS'(1), "post_reset_col", int'(col_o), 1);
        tick(40);
        press_key(1, 2, '0, 1'b1, -1, h0);
        release_key(2);

        drain();
        check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        check(ov_seen == ov_exp, "overrun_count", ov_seen, ov_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
